uart_tx_scheduler: RTL
======================

# uart_tx_scheduler

Round-robin scheduler that shares the single transmitter of `uart_full_duplex` between several on-chip byte producers. It accepts bytes over per-requester valid/ready handshakes and drives the UART `tx_start`/`tx_data` pair. It observes `tx_busy` to pace transfers. A requester can lock the transmitter for a multi-byte packet using a `last` flag. Hung handshakes are recovered by timeouts.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ACK_TIMEOUT`, default 16: cycles allowed for `tx_busy` to rise after a `tx_start` pulse.
- `LOCK_TIMEOUT`, default 65535: idle cycles a locked requester may hold the grant without presenting a byte.
- `IDW`, default `$clog2(NUM_REQ)`: grant index width.

Ports (clock and reset first):
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset asserted); release is synchronous to `clk` upstream.
- `req_valid`  in  NUM_REQ  per-requester byte-available flag.
- `req_data`  in  8*NUM_REQ  byte of requester i in bits [8i+7:8i].
- `req_last`  in  NUM_REQ  1 = this byte ends the requester's packet.
- `req_ready`  out  NUM_REQ  one-hot, one-cycle pulse marking the byte as consumed.
- `tx_start`  out  1  one-cycle start pulse to the UART transmitter.
- `tx_data`  out  8  byte to the UART; held stable until the next load.
- `tx_busy`  in  1  busy flag from the UART transmitter.
- `grant_id`  out  IDW  index of the current or most recent grantee.
- `grant_active`  out  1  high while a requester holds the transmitter.
- `err_timeout`  out  1  one-cycle pulse on an ACK or LOCK timeout.

## Operation
- States: IDLE, LOAD, WAIT_ACK, WAIT_DONE, HOLD.
- **IDLE**
  - If any `req_valid` is set, select the first set bit searching from `(last_grant+1) mod NUM_REQ` upward with wrap-around.
  - Register the selection in `grant_id`, set `grant_active`, and go to LOAD.
  - With no request, stay in IDLE.
- **LOAD** (exactly 1 cycle)
  - `tx_data <= req_data[grant_id]`.
  - Pulse `tx_start` and `req_ready[grant_id]`.
  - Latch `lock = ~req_last[grant_id]`, clear the counter, go to WAIT_ACK.
- **WAIT_ACK**
  - Counter increments each cycle.
  - On `tx_busy=1`, go to WAIT_DONE.
  - If the counter reaches ACK_TIMEOUT first: pulse `err_timeout`, clear `lock`, set `last_grant=grant_id`, clear `grant_active`, go to IDLE. The byte is lost.
- **WAIT_DONE**
  - Wait for `tx_busy=0`, then:
  - if `lock=0`: set `last_grant=grant_id`, clear `grant_active`, go to IDLE;
  - else if `req_valid[grant_id]=1`: go to LOAD;
  - otherwise clear the counter and go to HOLD.
- **HOLD**
  - Counter increments each cycle.
  - `req_valid[grant_id]=1` goes to LOAD; other requesters are ignored.
  - If the counter reaches LOCK_TIMEOUT first: pulse `err_timeout`, release exactly as for `lock=0`.
- Requester contract:
  - hold `req_data`/`req_last` stable while `req_valid` is high until `req_ready`;
  - `req_valid` may drop before `req_ready`, and the scheduler re-evaluates only in IDLE/HOLD.
- Counter width is `$clog2(max(ACK_TIMEOUT,LOCK_TIMEOUT)+1)` and saturates; it never wraps.
- `last_grant` resets to `NUM_REQ-1`, so the first arbitration favours requester 0.

## Timing
- Reset values: state IDLE, `req_ready=0`, `tx_start=0`, `tx_data=8'h00`, `grant_id=0`, `grant_active=0`, `err_timeout=0`, `lock=0`.
- Reset mid-transfer aborts immediately to IDLE with all outputs at reset values; the UART in flight is not stalled.
- All outputs are registered.
- Request to `tx_start`: 2 cycles (IDLE decision cycle, then LOAD); `req_ready` coincides with `tx_start`.
- Locked back-to-back bytes: the next LOAD is the cycle after `tx_busy` falls, so the gap is 1 cycle plus the UART frame.
- `tx_busy` already high on entry to WAIT_ACK is accepted immediately; a low pulse shorter than 1 cycle is not detected.
- Simultaneous requests are resolved in one cycle by round-robin; requests arriving mid-packet wait for release.
- `err_timeout` and the release transition occur in the same cycle the counter hits its limit.

## Test plan
- Single byte: req0 `valid`, data 8'hA5, `last=1` → `tx_start` and `req_ready[0]` 2 cycles later, `tx_data=8'hA5`, `grant_active` drops the cycle after `tx_busy` falls.
- Fairness: all four requesters continuously valid with `last=1` → grant order 0,1,2,3,0,1 and `tx_data` matches each requester's byte.
- Lock: req2 sends 8'h10, 8'h11, 8'h12 (`last` on the third) while req0 and req1 stay valid → three consecutive grants to 2, then grant 3? no, the next grant is 0.
- ACK timeout: hold `tx_busy=0` after `tx_start` → `err_timeout` pulse exactly ACK_TIMEOUT cycles later, return to IDLE, the next requester is served.
- LOCK timeout (LOCK_TIMEOUT=8): req1 sends a byte with `last=0` then drops `valid` → HOLD for 8 cycles, `err_timeout`, req3 granted next.
- Reset mid-frame: assert `rst=0` during WAIT_DONE → all outputs at reset values immediately; after release, req0 is served first.

Source files
------------

// File: rtl/uart_tx_scheduler_if.sv
// Requester handshakes plus the UART transmitter pair. The scheduler uses the slave view.
// The requesters and the UART use the master view.
interface uart_tx_scheduler_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic [IDW-1:0]       grant_id;
  logic                 grant_active;
  logic                 err_timeout;

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_start, tx_data, grant_id, grant_active, err_timeout
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_start, tx_data, grant_id, grant_active, err_timeout
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one UART transmitter between byte producers.
// A producer locks the transmitter until its last byte is sent; ACK and LOCK timeouts recover hung handshakes.
module uart_tx_scheduler #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned ACK_TIMEOUT  = 16,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned IDW          = $clog2(NUM_REQ)
) (
  input logic               clk,
  input logic               rst,
  uart_tx_scheduler_if.slave sched
);

  localparam int unsigned MAXT = (ACK_TIMEOUT > LOCK_TIMEOUT) ? ACK_TIMEOUT : LOCK_TIMEOUT;
  localparam int unsigned CW   = $clog2(MAXT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_ACK, WAIT_DONE, HOLD} state_e;

  state_e               state_q, state_d;
  logic [IDW-1:0]       grantId_q, grantId_d;
  logic [IDW-1:0]       lastGrant_q, lastGrant_d;
  logic                 grantActive_q, grantActive_d;
  logic                 lock_q, lock_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [7:0]           txData_q, txData_d;
  logic                 txStart_q, txStart_d;
  logic [NUM_REQ-1:0]   reqReady_q, reqReady_d;
  logic                 errTimeout_q, errTimeout_d;

  logic [IDW:0]         candSum;
  logic [IDW-1:0]       cand;
  logic [IDW-1:0]       pickIdx;
  logic                 pickFound;
  logic [CW-1:0]        cntInc;

  // Search starts just after the previous grantee and wraps, giving round-robin order.
  always_comb begin
    pickFound = 1'b0;
    pickIdx   = lastGrant_q;
    candSum   = '0;
    cand      = '0;
    for (int i = 1; i <= int'(NUM_REQ); i++) begin
      candSum = {1'b0, lastGrant_q} + (IDW+1)'(i);
      if (candSum >= (IDW+1)'(NUM_REQ)) begin
        candSum = candSum - (IDW+1)'(NUM_REQ);
      end
      cand = candSum[IDW-1:0];
      if (!pickFound && sched.req_valid[cand]) begin
        pickFound = 1'b1;
        pickIdx   = cand;
      end
    end
  end

  assign cntInc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d       = state_q;
    grantId_d     = grantId_q;
    lastGrant_d   = lastGrant_q;
    grantActive_d = grantActive_q;
    lock_d        = lock_q;
    cnt_d         = cnt_q;
    txData_d      = txData_q;
    txStart_d     = 1'b0;
    reqReady_d    = '0;
    errTimeout_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pickFound) begin
          grantId_d     = pickIdx;
          grantActive_d = 1'b1;
          state_d       = LOAD;
        end
      end
      LOAD: begin
        txData_d              = sched.req_data[{grantId_q, 3'b000} +: 8];
        txStart_d             = 1'b1;
        reqReady_d[grantId_q] = 1'b1;
        lock_d                = ~sched.req_last[grantId_q];
        cnt_d                 = '0;
        state_d               = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (sched.tx_busy) begin
          state_d = WAIT_DONE;
        end else begin
          cnt_d = cntInc;
          if (cntInc == CW'(ACK_TIMEOUT)) begin
            errTimeout_d  = 1'b1;
            lock_d        = 1'b0;
            lastGrant_d   = grantId_q;
            grantActive_d = 1'b0;
            state_d       = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!sched.tx_busy) begin
          if (!lock_q) begin
            lastGrant_d   = grantId_q;
            grantActive_d = 1'b0;
            state_d       = IDLE;
          end else if (sched.req_valid[grantId_q]) begin
            state_d = LOAD;
          end else begin
            cnt_d   = '0;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // While locked only the grantee is considered; everyone else waits for release.
        if (sched.req_valid[grantId_q]) begin
          state_d = LOAD;
        end else begin
          cnt_d = cntInc;
          if (cntInc == CW'(LOCK_TIMEOUT)) begin
            errTimeout_d  = 1'b1;
            lock_d        = 1'b0;
            lastGrant_d   = grantId_q;
            grantActive_d = 1'b0;
            state_d       = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // lastGrant resets to the top index so the first arbitration favours requester 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      grantId_q     <= '0;
      lastGrant_q   <= IDW'(NUM_REQ - 1);
      grantActive_q <= 1'b0;
      lock_q        <= 1'b0;
      cnt_q         <= '0;
      txData_q      <= 8'h00;
      txStart_q     <= 1'b0;
      reqReady_q    <= '0;
      errTimeout_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      grantId_q     <= grantId_d;
      lastGrant_q   <= lastGrant_d;
      grantActive_q <= grantActive_d;
      lock_q        <= lock_d;
      cnt_q         <= cnt_d;
      txData_q      <= txData_d;
      txStart_q     <= txStart_d;
      reqReady_q    <= reqReady_d;
      errTimeout_q  <= errTimeout_d;
    end
  end

  assign sched.req_ready    = reqReady_q;
  assign sched.tx_start     = txStart_q;
  assign sched.tx_data      = txData_q;
  assign sched.grant_id     = grantId_q;
  assign sched.grant_active = grantActive_q;
  assign sched.err_timeout  = errTimeout_q;

endmodule
